// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store access unit: size codes, FSM encoding, default widths.
package mem_access_unit_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Lane steering: alignment check, byte enables, store replication and load extraction/extension.
module load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH
) (
  input  logic [1:0]            size,
  input  logic [1:0]            lane,
  input  logic                  ld_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  output logic [DATA_WIDTH-1:0] ld_ext,
  output logic                  misalign
);

  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign byte_shift = mem_rdata >> {lane, 3'b000};
  assign half_shift = mem_rdata >> {lane[1], 4'b0000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = half_shift[15:0];

  always_comb begin
    be        = '1;
    wdata_rep = wdata;
    ld_ext    = mem_rdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = BE_WIDTH'(1) << lane;
        wdata_rep = {(DATA_WIDTH/8){wdata[7:0]}};
        ld_ext    = {{(DATA_WIDTH-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misalign  = lane[0];
        be        = BE_WIDTH'(3) << lane;
        wdata_rep = {(DATA_WIDTH/16){wdata[15:0]}};
        ld_ext    = {{(DATA_WIDTH-16){~ld_unsigned & ld_half[15]}}, ld_half};
      end
      default: misalign = |lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store sequencer driving a word-wide request/ack memory port.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BE_WIDTH   = DEF_BE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            size,
  input  logic                  ld_unsigned,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  logic [1:0]            state;
  logic                  we_q, uns_q, mis_q;
  logic [1:0]            size_q, lane_q;
  logic                  accept;
  logic [1:0]            al_size, al_lane;
  logic                  al_uns, al_mis;
  logic [BE_WIDTH-1:0]   al_be;
  logic [DATA_WIDTH-1:0] al_wdata, al_ld;

  assign accept   = (state == ST_IDLE) && start && (MemRead || MemWrite);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_RESP);
  assign misalign = done & mis_q;

  // One aligner serves both phases: live inputs while idle, captured command afterwards.
  assign al_size = (state == ST_IDLE) ? size        : size_q;
  assign al_lane = (state == ST_IDLE) ? addr[1:0]   : lane_q;
  assign al_uns  = (state == ST_IDLE) ? ld_unsigned : uns_q;

  load_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_align (
    .size        (al_size),
    .lane        (al_lane),
    .ld_unsigned (al_uns),
    .wdata       (wdata),
    .mem_rdata   (mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .ld_ext      (al_ld),
    .misalign    (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      lane_q    <= 2'b00;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q   <= MemWrite;
            size_q <= size;
            uns_q  <= ld_unsigned;
            lane_q <= addr[1:0];
            mis_q  <= al_mis;
            if (al_mis) begin
              state <= ST_RESP;
            end else begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (!we_q) rdata <= al_ld;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, MemRead, MemWrite, ld_unsigned, mem_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, misalign, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .BE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    case (nbytes(sz))
      1:       return (w & 32'hFF) * 32'h0101_0101;
      2:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input bit uns, input logic [31:0] r);
    longint unsigned v, lim;
    int n = nbytes(sz);
    if (n == 4) return r;
    lim = 64'd1 << (8 * n);
    v   = (longint'(r) >> (8 * (a % 4))) % lim;
    if (!uns && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  task automatic scramble_inputs();
    MemRead     = 1'($urandom);
    MemWrite    = 1'($urandom);
    size        = 2'($urandom);
    ld_unsigned = 1'($urandom);
    addr        = $urandom;
    wdata       = $urandom;
  endtask

  // Drives one command from #1 after a rising edge and follows it to completion.
  task automatic run_cmd(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] w, input logic [31:0] r,
                         input int delay, input bit poke);
    bit          mis = m_mis(sz, a);
    logic [3:0]  be  = m_be(sz, a);
    logic [31:0] wd  = m_wdata(sz, w);
    start = 1'b1; MemRead = rd; MemWrite = wr; size = sz; ld_unsigned = uns; addr = a; wdata = w;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    if (!rd && !wr) begin
      check_val("nocmd_busy", 32'(busy), 32'd0);
      check_val("nocmd_req", 32'(mem_req), 32'd0);
      return;
    end
    if (mis) begin
      check_val("mis_done", 32'(done), 32'd1);
      check_val("mis_flag", 32'(misalign), 32'd1);
      check_val("mis_req", 32'(mem_req), 32'd0);
      check_val("mis_rdata", rdata, exp_rdata);
      @(posedge clk); #1;
      check_val("mis_after_done", 32'(done), 32'd0);
      check_val("mis_after_busy", 32'(busy), 32'd0);
      return;
    end
    check_val("req", 32'(mem_req), 32'd1);
    check_val("we", 32'(mem_we), 32'(wr));
    check_val("addr", mem_addr, a & 32'hFFFF_FFFC);
    check_val("be", 32'(mem_be), 32'(be));
    if (wr) check_val("wdata", mem_wdata, wd);
    check_val("req_done", 32'(done), 32'd0);
    for (int i = 0; i < delay; i++) begin
      mem_ack = 1'b0;
      if (poke && i == 0) begin
        start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; size = 2'b00; addr = a ^ 32'h5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_val("hold_req", 32'(mem_req), 32'd1);
      check_val("hold_addr", mem_addr, a & 32'hFFFF_FFFC);
      check_val("hold_be", 32'(mem_be), 32'(be));
      check_val("hold_we", 32'(mem_we), 32'(wr));
      if (wr) check_val("hold_wdata", mem_wdata, wd);
      check_val("hold_done", 32'(done), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = r;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (!wr) exp_rdata = m_load(sz, a, uns, r);
    check_val("resp_done", 32'(done), 32'd1);
    check_val("resp_mis", 32'(misalign), 32'd0);
    check_val("resp_req", 32'(mem_req), 32'd0);
    check_val("rdata", rdata, exp_rdata);
    @(posedge clk); #1;
    check_val("idle_done", 32'(done), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'b00;
    ld_unsigned = 1'b0; addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #2;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_be", 32'(mem_be), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_cmd(1, 0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0);
    check_val("dir_lb", rdata, 32'hFFFF_FF80);
    run_cmd(1, 0, 2'b01, 1, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 0);
    check_val("dir_lhu", rdata, 32'h0000_BEEF);
    run_cmd(0, 1, 2'b01, 0, 32'h10, 32'h0000_ABCD, 32'h0, 0, 0);
    check_val("dir_sh_keeps_rdata", rdata, 32'h0000_BEEF);
    run_cmd(1, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 0, 0);
    run_cmd(1, 1, 2'b10, 0, 32'h40, 32'h1234_5678, 32'h0, 5, 1);
    run_cmd(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 0);

    // Reset during an outstanding request
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; size = 2'b10; addr = 32'h80;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("rstmid_req_pre", 32'(mem_req), 32'd1);
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    exp_rdata = '0;
    check_val("rstmid_req", 32'(mem_req), 32'd0);
    check_val("rstmid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_val("rstmid_done", 32'(done), 32'd0);
    rst_n = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    check_val("rstmid_post_done", 32'(done), 32'd0);
    check_val("rstmid_post_busy", 32'(busy), 32'd0);
    check_val("rstmid_rdata", rdata, exp_rdata);

    // Randomized commands, with stray acks while idle
    for (int n = 0; n < 300; n++) begin
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check_val("stray_ack_rdata", rdata, exp_rdata);
      check_val("stray_ack_done", 32'(done), 32'd0);
      run_cmd(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
